// File: rtl/ref_fetch_pkg.sv
// Shared constants, FSM encodings and the buffer tag layout for the
// reference-window fetch block.
package ref_fetch_pkg;

  localparam int DEF_FRAME_W   = 1920;
  localparam int DEF_WIN_WORDS = 6;
  localparam int DEF_WIN_ROWS  = 48;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // 10-bit position tag travelling with each pixel word
  typedef struct packed {
    logic [5:0] row;
    logic [2:0] col;
    logic       last;
  } tag_t;

endpackage

// File: rtl/ref_fetch_fifo.sv
// Two-entry FIFO carrying a pixel word plus its position tag; a push is
// accepted while full only when the head is popped in the same cycle.
module ref_fetch_fifo
  import ref_fetch_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  tag_t              wr_tag,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output tag_t              rd_tag,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] data_q [2];
  tag_t              tag_q  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is forced to zero while empty instead.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      data_q[wr_ptr] <= wr_data;
      tag_q[wr_ptr]  <= wr_tag;
    end
  end

  assign rd_data = empty ? '0 : data_q[rd_ptr];
  assign rd_tag  = empty ? '0 : tag_q[rd_ptr];

endmodule

// File: rtl/ref_fetch.sv
// Fetches a WIN_WORDS x WIN_ROWS search window from reference memory in
// raster order and streams it out through a 2-entry buffer.
module ref_fetch
  import ref_fetch_pkg::*;
#(
  parameter int FRAME_W   = DEF_FRAME_W,
  parameter int WIN_WORDS = DEF_WIN_WORDS,
  parameter int WIN_ROWS  = DEF_WIN_ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [63:0] mem_data,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [63:0] win_data,
  output logic [5:0]  win_row,
  output logic [2:0]  win_col,
  output logic        win_last,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0]  LAST_COL = 3'(WIN_WORDS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(WIN_ROWS - 1);
  localparam logic [31:0] PITCH    = 32'(FRAME_W);

  logic [1:0]  state;
  logic [31:0] row_base;
  logic [2:0]  col;
  logic [5:0]  row;
  logic        fifo_full;
  logic        fifo_empty;
  logic        last_rd;
  logic        xfer;
  tag_t        wr_tag;
  tag_t        rd_tag;

  // Read enable depends only on pre-pop fullness, never on win_ready.
  assign mem_en   = (state == ST_FETCH) && !fifo_full;
  assign mem_addr = mem_en ? (row_base + {26'd0, col, 3'b000}) : '0;
  assign last_rd  = (row == LAST_ROW) && (col == LAST_COL);
  assign wr_tag   = '{row: row, col: col, last: last_rd};

  assign win_valid = !fifo_empty;
  assign xfer      = win_valid && win_ready;
  assign win_row   = rd_tag.row;
  assign win_col   = rd_tag.col;
  assign win_last  = rd_tag.last;
  assign busy      = (state != ST_IDLE);

  ref_fetch_fifo #(.DATA_W(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_en),
    .wr_data (mem_data),
    .wr_tag  (wr_tag),
    .rd_en   (xfer),
    .rd_data (win_data),
    .rd_tag  (rd_tag),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      row_base <= '0;
      col      <= '0;
      row      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            row_base <= base_addr;
            col      <= '0;
            row      <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (mem_en) begin
            if (col == LAST_COL) begin
              col      <= '0;
              row      <= row + 6'd1;
              row_base <= row_base + PITCH;
              if (row == LAST_ROW) state <= ST_DRAIN;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer && win_last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_fetch.sv
// Directed bench for ref_fetch: full windows, back-pressure, address wrap,
// ignored restart and mid-window reset, against a behavioural memory model.
module tb_ref_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic        win_valid;
  logic        win_ready;
  logic [63:0] win_data;
  logic [5:0]  win_row;
  logic [2:0]  win_col;
  logic        win_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ref_fetch #(.FRAME_W(1920), .WIN_WORDS(6), .WIN_ROWS(48)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
  );

  // Byte at address a holds (a+1) mod 256; words are big-endian.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [63:0] w;
    logic [31:0] b;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      b = a + 32'(i) + 32'd1;
      w[63-8*i -: 8] = b[7:0];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int k);
    return base + 32'(k / 6) * 32'd1920 + 32'(k % 6) * 32'd8;
  endfunction

  always_comb mem_data = mem_word(mem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_en"},    64'(mem_en),    64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    chk({tag, "_win_data"},  win_data,       64'd0);
    chk({tag, "_win_row"},   64'(win_row),   64'd0);
    chk({tag, "_win_col"},   64'(win_col),   64'd0);
    chk({tag, "_win_last"},  64'(win_last),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
  endtask

  // One window: start at cycle 0, win_ready low for the first `stall`
  // cycles, optional second start at word restart_at, optional reset at
  // word abort_at. addr1/addr6 capture the 2nd and 7th read addresses.
  task automatic run_stream(input logic [31:0] base, input int stall,
                            input int restart_at, input int abort_at,
                            output logic [31:0] addr1, output logic [31:0] addr6);
    int   wc, rd, cyc, dones, first_valid, last_xfer, done_cyc;
    bit   restarted, fin;
    logic [31:0] a;
    wc = 0; rd = 0; cyc = 0; dones = 0; first_valid = -1;
    last_xfer = -1; done_cyc = -1; restarted = 0; fin = 0;
    addr1 = '1; addr6 = '1;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      start     = (cyc == 0);
      base_addr = (cyc == 0) ? base : 32'hDEAD_0000;
      if (restart_at >= 0 && wc == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      win_ready = (cyc >= stall);
      if (abort_at >= 0 && wc == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset("abort");
        @(posedge clk); #1;
        chk_reset("abort_hold");
        rst = 1'b0;
        return;
      end
      #1;
      if (cyc == 0) chk("busy_at_start", 64'(busy), 64'd0);
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (mem_en) begin
        a = exp_addr(base, rd);
        chk("mem_addr", 64'(mem_addr), 64'(a));
        if (rd == 1) addr1 = mem_addr;
        if (rd == 6) addr6 = mem_addr;
        rd++;
      end else begin
        chk("mem_addr_idle", 64'(mem_addr), 64'd0);
      end
      if (stall > 0 && cyc == stall - 1) begin
        chk("stall_reads", 64'(rd), 64'd2);
        chk("stall_mem_en", 64'(mem_en), 64'd0);
      end
      if (win_valid) begin
        if (first_valid < 0) first_valid = cyc;
        a = exp_addr(base, wc);
        chk("win_data", win_data, mem_word(a));
        chk("win_row", 64'(win_row), 64'(wc / 6));
        chk("win_col", 64'(win_col), 64'(wc % 6));
        chk("win_last", 64'(win_last), 64'(wc == 287));
        if (win_ready) begin
          last_xfer = cyc;
          wc++;
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 64'd0);
        fin = 1;
      end
      cyc++;
    end
    start = 1'b0;
    chk("timeout", 64'(fin), 64'd1);
    chk("word_count", 64'(wc), 64'd288);
    chk("read_count", 64'(rd), 64'd288);
    chk("done_timing", 64'(done_cyc), 64'(last_xfer + 1));
    if (stall == 0) chk("first_valid_latency", 64'(first_valid), 64'd2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      if (done) dones++;
      chk("idle_valid", 64'(win_valid), 64'd0);
      chk("idle_mem_en", 64'(mem_en), 64'd0);
    end
    chk("done_pulses", 64'(dones), 64'd1);
  endtask

  initial begin
    logic [31:0] a1, a6;
    rst = 1'b1; start = 1'b0; base_addr = '0; win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic window from 0x100 with continuous ready
    run_stream(32'h0000_0100, 0, -1, -1, a1, a6);
    chk("first_addr_plus8", 64'(a1), 64'h108);
    chk("seventh_addr", 64'(a6), 64'h880);
    chk("first_word_bytes", mem_word(32'h100), 64'h0102030405060708);

    // Back-pressure for 10 cycles after start
    run_stream(32'h0000_0100, 10, -1, -1, a1, a6);

    // Address wrap past 2^32
    run_stream(32'hFFFF_FFF8, 0, -1, -1, a1, a6);
    chk("wrap_second_addr", 64'(a1), 64'h0);

    // Second start mid-window is ignored
    run_stream(32'h0000_0100, 0, 100, -1, a1, a6);

    // Reset at word 50, then a fresh window from 0x200
    run_stream(32'h0000_0100, 0, -1, 50, a1, a6);
    repeat (3) begin
      @(posedge clk); #2;
      chk("post_abort_valid", 64'(win_valid), 64'd0);
      chk("post_abort_busy", 64'(busy), 64'd0);
    end
    run_stream(32'h0000_0200, 0, -1, -1, a1, a6);
    chk("restart_second_addr", 64'(a1), 64'h208);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
